// File: rtl/fpu_issue_sched_if.sv
// Request, issue and response signals between the two requesters,
// the shared FPU pipeline and the issue scheduler.
interface fpu_issue_sched_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [1:0]  req0_op;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic        req1_valid;
   logic        req1_ready;
   logic [1:0]  req1_op;
   logic [31:0] req1_a;
   logic [31:0] req1_b;
   logic        fpu_valid;
   logic [1:0]  fpu_op;
   logic [31:0] fpu_a;
   logic [31:0] fpu_b;
   logic [31:0] fpu_result;
   logic        rsp0_valid;
   logic [31:0] rsp0_data;
   logic        rsp0_err;
   logic        rsp1_valid;
   logic [31:0] rsp1_data;
   logic        rsp1_err;
   logic        flush;
   logic        busy;
   logic [4:0]  inflight;

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output fpu_result, flush,
      input  req0_ready, req1_ready,
      input  fpu_valid, fpu_op, fpu_a, fpu_b,
      input  rsp0_valid, rsp0_data, rsp0_err,
      input  rsp1_valid, rsp1_data, rsp1_err,
      input  busy, inflight
   );

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  fpu_result, flush,
      output req0_ready, req1_ready,
      output fpu_valid, fpu_op, fpu_a, fpu_b,
      output rsp0_valid, rsp0_data, rsp0_err,
      output rsp1_valid, rsp1_data, rsp1_err,
      output busy, inflight
   );
endinterface

// File: rtl/fpu_issue_sched.sv
// Round-robin issue scheduler for a shared FPU pipeline; supplies the
// valid/port/err tracking the pipeline stages lack and routes results back.
module fpu_issue_sched #(
   parameter int unsigned LATENCY = 4
) (
   input logic              clk,
   input logic              rst,
   fpu_issue_sched_if.slave bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] OP_RSV   = 2'b11;

   logic [1:0]       state;
   logic [3:0]       drain_cnt;
   logic             last_grant;
   logic [4:0]       inflight_q;
   logic [LATENCY:0] trk_v;
   logic [LATENCY:0] trk_port;
   logic [LATENCY:0] trk_err;

   logic             fpu_valid_q;
   logic [1:0]       fpu_op_q;
   logic [31:0]      fpu_a_q;
   logic [31:0]      fpu_b_q;
   logic             rsp0_valid_q, rsp1_valid_q;
   logic             rsp0_err_q, rsp1_err_q;
   logic [31:0]      rsp0_data_q, rsp1_data_q;

   logic             open, ready0, ready1, hs;
   logic [1:0]       sel_op;
   logic [31:0]      sel_a, sel_b;
   logic             tail_v, tail_port, tail_err, rsp_evt;

   // Port 1 wins a tie only when port 0 was granted last.
   always_comb begin
      open   = (state != ST_DRAIN) & ~bus.flush;
      ready0 = open & bus.req0_valid & (~bus.req1_valid | last_grant);
      ready1 = open & bus.req1_valid & (~bus.req0_valid | ~last_grant);
      hs     = ready0 | ready1;
      sel_op = ready1 ? bus.req1_op : bus.req0_op;
      sel_a  = ready1 ? bus.req1_a  : bus.req0_a;
      sel_b  = ready1 ? bus.req1_b  : bus.req0_b;
      tail_v    = trk_v[LATENCY];
      tail_port = trk_port[LATENCY];
      tail_err  = trk_err[LATENCY];
      rsp_evt   = tail_v & ~bus.flush;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         drain_cnt  <= '0;
         last_grant <= 1'b1;
         inflight_q <= '0;
      end else begin
         if (hs)
            last_grant <= ready1;
         inflight_q <= bus.flush ? '0 : inflight_q + {4'd0, hs} - {4'd0, rsp_evt};
         if (bus.flush) begin
            state     <= ST_DRAIN;
            drain_cnt <= 4'(LATENCY);
         end else begin
            case (state)
               ST_IDLE:  if (hs) state <= ST_RUN;
               ST_RUN:   if (inflight_q == '0 && !hs) state <= ST_IDLE;
               ST_DRAIN: begin
                  if (drain_cnt == '0) state <= ST_IDLE;
                  else                 drain_cnt <= drain_cnt - 4'd1;
               end
               default:  state <= ST_IDLE;
            endcase
         end
      end
   end

   // Entry 0 loads at the handshake edge so the tail lines up with fpu_result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trk_v    <= '0;
         trk_port <= '0;
         trk_err  <= '0;
      end else begin
         trk_v    <= bus.flush ? '0 : {trk_v[LATENCY-1:0], hs};
         trk_port <= {trk_port[LATENCY-1:0], ready1};
         trk_err  <= {trk_err[LATENCY-1:0], sel_op == OP_RSV};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fpu_valid_q <= 1'b0;
         fpu_op_q    <= '0;
         fpu_a_q     <= '0;
         fpu_b_q     <= '0;
      end else begin
         fpu_valid_q <= hs & (sel_op != OP_RSV);
         if (hs && sel_op != OP_RSV) begin
            fpu_op_q <= sel_op;
            fpu_a_q  <= sel_a;
            fpu_b_q  <= sel_b;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp0_valid_q <= 1'b0;
         rsp0_err_q   <= 1'b0;
         rsp0_data_q  <= '0;
         rsp1_valid_q <= 1'b0;
         rsp1_err_q   <= 1'b0;
         rsp1_data_q  <= '0;
      end else begin
         rsp0_valid_q <= rsp_evt & ~tail_port;
         rsp1_valid_q <= rsp_evt & tail_port;
         if (rsp_evt && !tail_port) begin
            rsp0_err_q  <= tail_err;
            rsp0_data_q <= tail_err ? '0 : bus.fpu_result;
         end
         if (rsp_evt && tail_port) begin
            rsp1_err_q  <= tail_err;
            rsp1_data_q <= tail_err ? '0 : bus.fpu_result;
         end
      end
   end

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign bus.fpu_valid  = fpu_valid_q;
   assign bus.fpu_op     = fpu_op_q;
   assign bus.fpu_a      = fpu_a_q;
   assign bus.fpu_b      = fpu_b_q;
   assign bus.rsp0_valid = rsp0_valid_q;
   assign bus.rsp0_data  = rsp0_data_q;
   assign bus.rsp0_err   = rsp0_err_q;
   assign bus.rsp1_valid = rsp1_valid_q;
   assign bus.rsp1_data  = rsp1_data_q;
   assign bus.rsp1_err   = rsp1_err_q;
   assign bus.busy       = (state != ST_IDLE);
   assign bus.inflight   = inflight_q;

endmodule
